// File: rtl/seq_signed_divider.sv
// Sequential restoring divider producing one quotient bit per clock, with
// valid/ready handshakes on the request and result sides.
module seq_signed_divider #(
    parameter int WIDTH  = 16,
    parameter int SIGNED = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_dividend;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;
    logic             r_ov;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_div_by_zero;
    logic             r_overflow;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_p_shift;
    logic [WIDTH-1:0] w_p_sub;
    logic             w_ge;

    assign w_a_neg = (SIGNED != 0) && dividend[WIDTH-1];
    assign w_b_neg = (SIGNED != 0) && divisor[WIDTH-1];
    assign w_a_mag = w_a_neg ? -dividend : dividend;
    assign w_b_mag = w_b_neg ? -divisor  : divisor;

    // The partial remainder stays below M after each step, so only the
    // shifted value needs the extra bit; the subtraction fits in WIDTH bits.
    assign w_p_shift = {r_p, r_q[WIDTH-1]};
    assign w_ge      = w_p_shift >= {1'b0, r_m};
    assign w_p_sub   = w_p_shift[WIDTH-1:0] - r_m;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid) w_next = CALC;
            CALC:    if (r_cnt == LAST) w_next = SIGN;
            SIGN:    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_p           <= '0;
            r_q           <= '0;
            r_m           <= '0;
            r_dividend    <= '0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_dz          <= 1'b0;
            r_ov          <= 1'b0;
            r_out_valid   <= 1'b0;
            r_quot        <= '0;
            r_rem         <= '0;
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: if (in_valid) begin
                    r_q        <= w_a_mag;
                    r_m        <= w_b_mag;
                    r_p        <= '0;
                    r_cnt      <= '0;
                    r_neg_q    <= w_a_neg ^ w_b_neg;
                    r_neg_r    <= w_a_neg;
                    r_dz       <= (divisor == '0);
                    r_ov       <= (SIGNED != 0) && (dividend == MIN) && (divisor == '1);
                    r_dividend <= dividend;
                end
                CALC: begin
                    r_p   <= w_ge ? w_p_sub : w_p_shift[WIDTH-1:0];
                    r_q   <= {r_q[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt + 1'b1;
                end
                SIGN: begin
                    r_out_valid   <= 1'b1;
                    r_div_by_zero <= r_dz;
                    r_overflow    <= r_ov;
                    if (r_dz) begin
                        r_quot <= '1;
                        r_rem  <= r_dividend;
                    end else begin
                        r_quot <= r_neg_q ? -r_q : r_q;
                        r_rem  <= r_neg_r ? -r_p : r_p;
                    end
                end
                DONE: if (out_ready) r_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = r_out_valid;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_div_by_zero;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Bench for seq_signed_divider: signed and unsigned instances share stimulus
// and are checked every cycle against a cycle-level arithmetic model.
module tb_seq_signed_divider;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         in_ready_s, in_ready_u, out_valid_s, out_valid_u;
    logic [W-1:0] q_s, r_s, q_u, r_u;
    logic         dz_s, ov_s, dz_u, ov_u;
    logic         rand_on = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_signed_divider #(.WIDTH(W), .SIGNED(1)) u_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid_s),
        .out_ready(out_ready), .quotient(q_s), .remainder(r_s),
        .div_by_zero(dz_s), .overflow(ov_s)
    );

    seq_signed_divider #(.WIDTH(W), .SIGNED(0)) u_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid_u),
        .out_ready(out_ready), .quotient(q_u), .remainder(r_u),
        .div_by_zero(dz_u), .overflow(ov_u)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic void ref_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic dz, output logic ov);
        logic signed [W-1:0] sa, sb;
        sa = a;
        sb = b;
        dz = (b == '0);
        ov = 1'b0;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (sgn && a == 16'h8000 && b == 16'hFFFF) begin
            q  = 16'h8000;
            r  = '0;
            ov = 1'b1;
        end else if (sgn) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Model: idle/busy, cycles since accept, pending result, visible result.
    bit           m_busy = 1'b0;
    bit           m_valid = 1'b0;
    int           m_cnt = 0;
    logic [W-1:0] m_q[2] = '{'0, '0};
    logic [W-1:0] m_r[2] = '{'0, '0};
    logic         m_dz[2] = '{1'b0, 1'b0};
    logic         m_ov[2] = '{1'b0, 1'b0};
    logic [W-1:0] p_q[2], p_r[2];
    logic         p_dz[2], p_ov[2];

    always @(negedge clk) begin
        logic [W-1:0] tq, tr;
        logic         tdz, tov;
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_cnt   = 0;
            for (int k = 0; k < 2; k++) begin
                m_q[k] = '0; m_r[k] = '0; m_dz[k] = 1'b0; m_ov[k] = 1'b0;
            end
        end
        check("in_ready_s",  in_ready_s,  !m_busy);
        check("in_ready_u",  in_ready_u,  !m_busy);
        check("out_valid_s", out_valid_s, m_valid);
        check("out_valid_u", out_valid_u, m_valid);
        check("quotient_s",  q_s,  m_q[0]);
        check("remainder_s", r_s,  m_r[0]);
        check("dbz_s",       dz_s, m_dz[0]);
        check("ovf_s",       ov_s, m_ov[0]);
        check("quotient_u",  q_u,  m_q[1]);
        check("remainder_u", r_u,  m_r[1]);
        check("dbz_u",       dz_u, m_dz[1]);
        check("ovf_u",       ov_u, m_ov[1]);
        if (rst_n) begin
            if (!m_busy) begin
                if (in_valid) begin
                    m_busy = 1'b1;
                    m_cnt  = 0;
                    for (int k = 0; k < 2; k++) begin
                        ref_div(k == 0, dividend, divisor, tq, tr, tdz, tov);
                        p_q[k] = tq; p_r[k] = tr; p_dz[k] = tdz; p_ov[k] = tov;
                    end
                end
            end else if (!m_valid) begin
                m_cnt++;
                if (m_cnt == W + 1) begin
                    m_valid = 1'b1;
                    for (int k = 0; k < 2; k++) begin
                        m_q[k] = p_q[k]; m_r[k] = p_r[k]; m_dz[k] = p_dz[k]; m_ov[k] = p_ov[k];
                    end
                end
            end else if (out_ready) begin
                m_valid = 1'b0;
                m_busy  = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (rand_on) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    // All directed tasks are entered and leave 1 time unit after a rising edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        while (!in_ready_s && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready_s) timeout("send");
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid_s && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid_s) timeout("wait_valid");
    endtask

    task automatic expect_res(input string name, input logic [W-1:0] qs, input logic [W-1:0] rs,
                              input logic dzs, input logic ovs,
                              input logic [W-1:0] qu, input logic [W-1:0] ru);
        check({name, "_q_s"},   q_s,  qs);
        check({name, "_r_s"},   r_s,  rs);
        check({name, "_dz_s"},  dz_s, dzs);
        check({name, "_ov_s"},  ov_s, ovs);
        check({name, "_q_u"},   q_u,  qu);
        check({name, "_r_u"},   r_u,  ru);
    endtask

    initial begin
        int lat;
        logic [W-1:0] a, b;

        @(posedge clk); #1;
        check("rst_in_ready", in_ready_s, 1'b1);
        check("rst_out_valid", out_valid_s, 1'b0);
        check("rst_quotient", q_s, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;

        send(16'd100, 16'd7);
        wait_valid(lat);
        check("lat_100_7", lat, 17);
        expect_res("d100_7", 16'd14, 16'd2, 1'b0, 1'b0, 16'd14, 16'd2);
        @(posedge clk); #1;
        check("in_ready_after_hs", in_ready_s, 1'b1);

        send(16'hFF9C, 16'd7);
        wait_valid(lat);
        expect_res("dm100_7", 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 16'h2484, 16'h0000);
        send(16'd100, 16'hFFF9);
        wait_valid(lat);
        expect_res("d100_m7", 16'hFFF2, 16'h0002, 1'b0, 1'b0, 16'h0000, 16'h0064);

        send(16'h8000, 16'hFFFF);
        wait_valid(lat);
        expect_res("dmin_m1", 16'h8000, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h8000);
        send(16'h8000, 16'h0001);
        wait_valid(lat);
        expect_res("dmin_1", 16'h8000, 16'h0000, 1'b0, 1'b0, 16'h8000, 16'h0000);

        send(16'h1234, 16'h0000);
        wait_valid(lat);
        check("lat_dbz", lat, 17);
        expect_res("d_by0", 16'hFFFF, 16'h1234, 1'b1, 1'b0, 16'hFFFF, 16'h1234);

        // Back-pressure with a pending request held on the input.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(16'd1000, 16'd33);
        wait_valid(lat);
        in_valid = 1'b1;
        dividend = 16'd500;
        divisor  = 16'd7;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_valid", out_valid_s, 1'b1);
            check("bp_quot", q_s, 16'd30);
            check("bp_rem", r_s, 16'd10);
            check("bp_in_ready", in_ready_s, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle", in_ready_s, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_accepted", in_ready_s, 1'b0);
        wait_valid(lat);
        check("lat_bp", lat, 17);
        expect_res("d500_7", 16'd71, 16'd3, 1'b0, 1'b0, 16'd71, 16'd3);

        // Asynchronous reset in the middle of a calculation.
        send(16'h7FFF, 16'd3);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid_s, 1'b0);
        check("arst_in_ready", in_ready_s, 1'b1);
        check("arst_quot", q_s, 16'h0000);
        check("arst_rem", r_s, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(16'd9, 16'd2);
        wait_valid(lat);
        expect_res("d9_2", 16'd4, 16'd1, 1'b0, 1'b0, 16'd4, 16'd1);

        // Random operands, gaps and back-pressure; the model checks every cycle.
        rand_on = 1'b1;
        for (int i = 0; i < 300; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            case ($urandom_range(0, 15))
                0: b = '0;
                1: begin a = 16'h8000; b = 16'hFFFF; end
                2, 3: b = W'($urandom_range(1, 15));
                4: b = W'(-$urandom_range(1, 15));
                default: ;
            endcase
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
            send(a, b);
        end
        rand_on = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        check("final_idle", in_ready_s, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
